rice_bus_slicer: RTL and testbench

//  Register slice for the rice bus, inserted between a bus master and a bus connector/slave to

---
 rtl/rice_bus_slicer_if.sv | 27 ++
 rtl/rice_bus_slicer.sv | 170 +++++++++++++++++
 tb/tb_rice_bus_slicer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rice_bus_slicer_if.sv
// Rice bus signal bundle: request channel (master -> slave) and response
// channel (slave -> master). The master modport drives requests and accepts
// responses; the slave modport is its mirror image.
interface rice_bus_slicer_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                      request_valid;
  logic                      request_ready;
  logic [ADDRESS_WIDTH-1:0]  address;
  logic [DATA_WIDTH/8-1:0]   strobe;
  logic [DATA_WIDTH-1:0]     write_data;
  logic                      response_valid;
  logic                      response_ready;
  logic [DATA_WIDTH-1:0]     read_data;
  logic                      error;

  modport master (
    output request_valid, address, strobe, write_data, response_ready,
    input  request_ready, response_valid, read_data, error
  );

  modport slave (
    input  request_valid, address, strobe, write_data, response_ready,
    output request_ready, response_valid, read_data, error
  );
endinterface

// File: rtl/rice_bus_slicer.sv
// Rice bus register slice. Each channel is either a 2-entry skid buffer
// (fully registered outputs, one beat per cycle under back-pressure) or a
// plain wire-through, selected per channel by parameter.

// Two-entry skid buffer carrying one opaque payload word.
//   state    | meaning
//   ST_EMPTY | nothing held, downstream valid low
//   ST_HALF  | main register holds the beat presented downstream
//   ST_FULL  | main + skid both hold beats, upstream ready low
module rice_bus_slicer_skid #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i
);
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             up_ready_q, up_ready_d;
  logic             dn_valid_q, dn_valid_d;
  logic             in_fire, out_fire;

  // State, payload and handshake flops; ready/valid are flopped copies of
  // the next-state decode so the outputs come straight from registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= up_ready_d;
      dn_valid_q <= dn_valid_d;
    end
  end

  // Next-state and payload steering.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = up_valid_i && up_ready_q;
    out_fire = dn_valid_q && dn_ready_i;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_HALF;
          main_d  = up_data_i;
        end
      end
      ST_HALF: begin
        if (in_fire && !out_fire) begin
          state_d = ST_FULL;
          skid_d  = up_data_i;
        end else if (!in_fire && out_fire) begin
          state_d = ST_EMPTY;
        end else if (in_fire && out_fire) begin
          main_d  = up_data_i;
        end
      end
      ST_FULL: begin
        // Upstream ready is low here, so only a drain can happen.
        if (out_fire) begin
          state_d = ST_HALF;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    up_ready_d = (state_d != ST_FULL);
    dn_valid_d = (state_d != ST_EMPTY);
  end

  assign up_ready_o = up_ready_q;
  assign dn_valid_o = dn_valid_q;
  assign dn_data_o  = main_q;
endmodule

module rice_bus_slicer #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter bit REQUEST_SLICE  = 1'b1,
  parameter bit RESPONSE_SLICE = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  rice_bus_slicer_if.slave    slave_if,
  rice_bus_slicer_if.master   master_if
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int REQ_WIDTH  = ADDRESS_WIDTH + STRB_WIDTH + DATA_WIDTH;
  localparam int RSP_WIDTH  = DATA_WIDTH + 1;

  generate
    if (REQUEST_SLICE) begin : g_req_slice
      logic [REQ_WIDTH-1:0] req_in;
      logic [REQ_WIDTH-1:0] req_out;
      logic                 req_ready;
      logic                 req_valid;

      assign req_in = {slave_if.address, slave_if.strobe, slave_if.write_data};

      rice_bus_slicer_skid #(.WIDTH(REQ_WIDTH)) u_req_skid (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .up_valid_i (slave_if.request_valid),
        .up_data_i  (req_in),
        .up_ready_o (req_ready),
        .dn_valid_o (req_valid),
        .dn_data_o  (req_out),
        .dn_ready_i (master_if.request_ready)
      );

      assign slave_if.request_ready = req_ready;
      assign master_if.request_valid = req_valid;
      assign {master_if.address, master_if.strobe, master_if.write_data} = req_out;
    end else begin : g_req_wire
      assign master_if.request_valid = slave_if.request_valid;
      assign master_if.address       = slave_if.address;
      assign master_if.strobe        = slave_if.strobe;
      assign master_if.write_data    = slave_if.write_data;
      assign slave_if.request_ready  = master_if.request_ready;
    end

    if (RESPONSE_SLICE) begin : g_rsp_slice
      logic [RSP_WIDTH-1:0] rsp_in;
      logic [RSP_WIDTH-1:0] rsp_out;
      logic                 rsp_ready;
      logic                 rsp_valid;

      assign rsp_in = {master_if.read_data, master_if.error};

      rice_bus_slicer_skid #(.WIDTH(RSP_WIDTH)) u_rsp_skid (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .up_valid_i (master_if.response_valid),
        .up_data_i  (rsp_in),
        .up_ready_o (rsp_ready),
        .dn_valid_o (rsp_valid),
        .dn_data_o  (rsp_out),
        .dn_ready_i (slave_if.response_ready)
      );

      assign master_if.response_ready = rsp_ready;
      assign slave_if.response_valid  = rsp_valid;
      assign {slave_if.read_data, slave_if.error} = rsp_out;
    end else begin : g_rsp_wire
      assign slave_if.response_valid  = master_if.response_valid;
      assign slave_if.read_data       = master_if.read_data;
      assign slave_if.error           = master_if.error;
      assign master_if.response_ready = slave_if.response_ready;
    end
  endgenerate
endmodule

// File: tb/tb_rice_bus_slicer.sv
// Bench for rice_bus_slicer: a registered instance checked against a
// queue-occupancy reference model, plus a pass-through instance.
module tb_rice_bus_slicer;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int RQW = AW + SW + DW;
  localparam int RSW = DW + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rice_bus_slicer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) up_if ();
  rice_bus_slicer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dn_if ();
  rice_bus_slicer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) pt_up ();
  rice_bus_slicer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) pt_dn ();

  rice_bus_slicer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                    .REQUEST_SLICE(1'b1), .RESPONSE_SLICE(1'b1)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .slave_if  (up_if),
    .master_if (dn_if)
  );

  rice_bus_slicer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
                    .REQUEST_SLICE(1'b0), .RESPONSE_SLICE(1'b0)) dut_pt (
    .i_clk     (clk),
    .i_rst     (rst),
    .slave_if  (pt_up),
    .master_if (pt_dn)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: accepted-but-undelivered beats per channel, in order.
  logic [RQW-1:0] q_req[$];
  logic [RSW-1:0] q_rsp[$];
  int req_delivered = 0;
  int rsp_delivered = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [RQW-1:0] rand_req();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[RQW-1:0];
  endfunction

  function automatic logic [RSW-1:0] rand_rsp();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[RSW-1:0];
  endfunction

  task automatic drive_req(input bit v, input logic [RQW-1:0] w);
    up_if.request_valid = v;
    {up_if.address, up_if.strobe, up_if.write_data} = w;
  endtask

  task automatic drive_rsp(input bit v, input logic [RSW-1:0] w);
    dn_if.response_valid = v;
    {dn_if.read_data, dn_if.error} = w;
  endtask

  // Outputs must reflect the model: valid iff something held, ready iff
  // fewer than two held, payload = oldest held beat.
  task automatic check_outputs(input string tag);
    chk({tag, ".req_valid"}, 128'(dn_if.request_valid), 128'(q_req.size() > 0));
    chk({tag, ".req_ready"}, 128'(up_if.request_ready), 128'(q_req.size() < 2));
    if (q_req.size() > 0)
      chk({tag, ".req_data"}, 128'({dn_if.address, dn_if.strobe, dn_if.write_data}), 128'(q_req[0]));
    chk({tag, ".rsp_valid"}, 128'(up_if.response_valid), 128'(q_rsp.size() > 0));
    chk({tag, ".rsp_ready"}, 128'(dn_if.response_ready), 128'(q_rsp.size() < 2));
    if (q_rsp.size() > 0)
      chk({tag, ".rsp_data"}, 128'({up_if.read_data, up_if.error}), 128'(q_rsp[0]));
  endtask

  // Called at a falling edge with inputs already applied; advances one
  // clock and checks at the next falling edge.
  task automatic cycle(input string tag, output bit rq_in, output bit rs_in);
    bit rq_out, rs_out;
    logic [RQW-1:0] rq_w;
    logic [RSW-1:0] rs_w;
    rq_in  = up_if.request_valid && (q_req.size() < 2);
    rq_out = (q_req.size() > 0) && dn_if.request_ready;
    rs_in  = dn_if.response_valid && (q_rsp.size() < 2);
    rs_out = (q_rsp.size() > 0) && up_if.response_ready;
    rq_w   = {up_if.address, up_if.strobe, up_if.write_data};
    rs_w   = {dn_if.read_data, dn_if.error};
    @(posedge clk);
    if (rq_out) begin void'(q_req.pop_front()); req_delivered++; end
    if (rq_in) q_req.push_back(rq_w);
    if (rs_out) begin void'(q_rsp.pop_front()); rsp_delivered++; end
    if (rs_in) q_rsp.push_back(rs_w);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".req_valid"},  128'(dn_if.request_valid),  128'(0));
    chk({tag, ".rsp_valid"},  128'(up_if.response_valid), 128'(0));
    chk({tag, ".req_ready"},  128'(up_if.request_ready),  128'(1));
    chk({tag, ".rsp_ready"},  128'(dn_if.response_ready), 128'(1));
    chk({tag, ".address"},    128'(dn_if.address),        128'(0));
    chk({tag, ".strobe"},     128'(dn_if.strobe),         128'(0));
    chk({tag, ".write_data"}, 128'(dn_if.write_data),     128'(0));
    chk({tag, ".read_data"},  128'(up_if.read_data),      128'(0));
    chk({tag, ".error"},      128'(up_if.error),          128'(0));
  endtask

  initial begin
    bit rqf, rsf, done;
    int cyc;

    drive_req(1'b0, '0);
    drive_rsp(1'b0, '0);
    dn_if.request_ready  = 1'b1;
    up_if.response_ready = 1'b1;
    pt_up.request_valid = 1'b0; pt_up.address = '0; pt_up.strobe = '0;
    pt_up.write_data = '0; pt_up.response_ready = 1'b0;
    pt_dn.request_ready = 1'b0; pt_dn.response_valid = 1'b0;
    pt_dn.read_data = '0; pt_dn.error = 1'b0;

    // Reset asserted mid-cycle takes effect without a clock edge.
    #2 rst = 1'b1;
    #1 check_reset_values("rst0");
    @(negedge clk);
    rst = 1'b0;
    check_outputs("rst0.idle");

    // Streaming: eight requests back to back, downstream always ready.
    for (int i = 0; i < 8; i++) begin
      drive_req(1'b1, {32'(i * 4), 4'hF, $urandom});
      cycle("stream", rqf, rsf);
      chk("stream.ready_high", 128'(up_if.request_ready), 128'(1));
    end
    drive_req(1'b0, '0);
    cycle("stream.drain", rqf, rsf);

    // Back-pressure: two beats fill the slice, ready drops until drain.
    dn_if.request_ready = 1'b0;
    drive_req(1'b1, {32'h100, 4'h3, 32'hA5A5_0100});
    cycle("bp", rqf, rsf);
    drive_req(1'b1, {32'h104, 4'hC, 32'hA5A5_0104});
    cycle("bp", rqf, rsf);
    chk("bp.ready_low", 128'(up_if.request_ready), 128'(0));
    drive_req(1'b0, '0);
    cycle("bp.hold", rqf, rsf);
    chk("bp.hold_addr", 128'(dn_if.address), 128'(32'h100));
    dn_if.request_ready = 1'b1;
    cycle("bp.release", rqf, rsf);
    chk("bp.ready_back", 128'(up_if.request_ready), 128'(1));
    chk("bp.second_addr", 128'(dn_if.address), 128'(32'h104));
    cycle("bp.drain", rqf, rsf);

    // Response path with the master's ready toggling.
    up_if.response_ready = 1'b0;
    drive_rsp(1'b1, {32'hDEAD_BEEF, 1'b1});
    cycle("rsp", rqf, rsf);
    drive_rsp(1'b1, {32'h1234_5678, 1'b0});
    cycle("rsp", rqf, rsf);
    drive_rsp(1'b0, '0);
    chk("rsp.first_data", 128'({up_if.read_data, up_if.error}), 128'({32'hDEAD_BEEF, 1'b1}));
    for (int i = 0; i < 6; i++) begin
      up_if.response_ready = (i % 2 == 0);
      cycle("rsp.toggle", rqf, rsf);
    end
    chk("rsp.all_out", 128'(up_if.response_valid), 128'(0));
    up_if.response_ready = 1'b1;

    // Random traffic on both channels; upstream holds while stalled.
    rqf = 1'b0; rsf = 1'b0;
    req_delivered = 0; rsp_delivered = 0;
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 60000) begin
      if (!up_if.request_valid || rqf) drive_req($urandom_range(0, 3) != 0, rand_req());
      if (!dn_if.response_valid || rsf) drive_rsp($urandom_range(0, 3) != 0, rand_rsp());
      dn_if.request_ready  = ($urandom_range(0, 3) != 0);
      up_if.response_ready = ($urandom_range(0, 3) != 0);
      cycle("rand", rqf, rsf);
      cyc++;
      done = (req_delivered >= 10000) && (rsp_delivered >= 10000);
    end
    chk("rand.completed", 128'(done), 128'(1));

    // Reset in the middle of traffic with beats held in both channels.
    dn_if.request_ready  = 1'b0;
    up_if.response_ready = 1'b0;
    drive_req(1'b1, rand_req());
    drive_rsp(1'b1, rand_rsp());
    cycle("pre_rst", rqf, rsf);
    drive_req(1'b1, rand_req());
    drive_rsp(1'b1, rand_rsp());
    cycle("pre_rst", rqf, rsf);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("rst1");
    q_req.delete();
    q_rsp.delete();
    drive_req(1'b0, '0);
    drive_rsp(1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    dn_if.request_ready  = 1'b1;
    up_if.response_ready = 1'b1;
    drive_req(1'b1, {32'h200, 4'h5, 32'h0BAD_F00D});
    drive_rsp(1'b1, {32'hCAFE_0001, 1'b0});
    cycle("post_rst", rqf, rsf);
    drive_req(1'b0, '0);
    drive_rsp(1'b0, '0);
    cycle("post_rst", rqf, rsf);

    // Pass-through instance: outputs follow inputs in the same cycle.
    for (int i = 0; i < 16; i++) begin
      pt_up.request_valid  = $urandom_range(0, 1) != 0;
      pt_up.address        = $urandom;
      pt_up.strobe         = 4'($urandom);
      pt_up.write_data     = $urandom;
      pt_up.response_ready = $urandom_range(0, 1) != 0;
      pt_dn.request_ready  = $urandom_range(0, 1) != 0;
      pt_dn.response_valid = $urandom_range(0, 1) != 0;
      pt_dn.read_data      = $urandom;
      pt_dn.error          = $urandom_range(0, 1) != 0;
      #1;
      chk("pt.req_valid", 128'(pt_dn.request_valid), 128'(pt_up.request_valid));
      chk("pt.req_data", 128'({pt_dn.address, pt_dn.strobe, pt_dn.write_data}),
          128'({pt_up.address, pt_up.strobe, pt_up.write_data}));
      chk("pt.req_ready", 128'(pt_up.request_ready), 128'(pt_dn.request_ready));
      chk("pt.rsp_valid", 128'(pt_up.response_valid), 128'(pt_dn.response_valid));
      chk("pt.rsp_data", 128'({pt_up.read_data, pt_up.error}), 128'({pt_dn.read_data, pt_dn.error}));
      chk("pt.rsp_ready", 128'(pt_dn.response_ready), 128'(pt_up.response_ready));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
